// File: rtl/rvv_backend_dispatch_pkg.sv
// Shared dispatch types: per-uop RAW hit/wait bundle, registered bypass selects, scheduler states.
// ROB_DEPTH falls back to 8 when the build does not define it.
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif

package rvv_backend_dispatch_pkg;

  localparam int unsigned RVV_ROB_DEPTH = `ROB_DEPTH;

  typedef struct packed {
    logic [RVV_ROB_DEPTH-1:0] vs1_hit;
    logic [RVV_ROB_DEPTH-1:0] vs2_hit;
    logic [RVV_ROB_DEPTH-1:0] vd_hit;
    logic [RVV_ROB_DEPTH-1:0] v0_hit;
    logic                     vs1_wait;
    logic                     vs2_wait;
    logic                     vd_wait;
    logic                     v0_wait;
  } RAW_UOP_ROB_t;

  typedef struct packed {
    logic [RVV_ROB_DEPTH-1:0] vs1;
    logic [RVV_ROB_DEPTH-1:0] vs2;
    logic [RVV_ROB_DEPTH-1:0] vd;
    logic [RVV_ROB_DEPTH-1:0] v0;
  } DISP_RAW_SEL_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } DISP_SCHED_STATE_e;

endpackage

// File: rtl/rvv_backend_dispatch_youngest_sel.sv
// One-hot of the ROB hit with the greatest age relative to the head pointer (zero if no hit).
// Walks entries oldest-to-youngest so the last hit seen wins; ROB_DEPTH must be a power of two.
module rvv_backend_dispatch_youngest_sel #(
  parameter int unsigned ROB_DEPTH = `ROB_DEPTH
) (
  input  logic [ROB_DEPTH-1:0]         hit_i,
  input  logic [$clog2(ROB_DEPTH)-1:0] head_i,
  output logic [ROB_DEPTH-1:0]         sel_o
);

  localparam int unsigned PTR_W = $clog2(ROB_DEPTH);

  logic [PTR_W-1:0] idx;

  // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    sel_o = '0;
    idx   = '0;
    for (int j = 0; j < ROB_DEPTH; j++) begin
      idx = head_i + j[PTR_W-1:0];
      if (hit_i[idx]) begin
        sel_o      = '0;
        sel_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvv_backend_dispatch_raw_sched.sv
// In-order dispatch scheduler: RAW/resource gating, RUN/STALL/FLUSH FSM, registered bypass selects.
// Optional `RVV_DISPATCH_STALL_PERF_EN adds a saturating 32-bit total-stall-cycle counter output.
module rvv_backend_dispatch_raw_sched
  import rvv_backend_dispatch_pkg::*;
#(
  parameter int unsigned DISP_NUM      = 2,
  parameter int unsigned ROB_DEPTH     = `ROB_DEPTH,
  parameter int unsigned STALL_TIMEOUT = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DISP_NUM-1:0]                  uop_valid,
  output logic [DISP_NUM-1:0]                  uop_ready,
  input  RAW_UOP_ROB_t [DISP_NUM-1:0]          raw_uop_rob,
  input  logic [DISP_NUM-2:0]                  raw_uop_uop,
  input  logic [$clog2(ROB_DEPTH)-1:0]         rob_head_ptr,
  input  logic [$clog2(ROB_DEPTH):0]           rob_free_num,
  input  logic [DISP_NUM-1:0]                  rs_ready,
  input  logic                                 trap_flush,
  output logic [DISP_NUM-1:0]                  disp_valid,
  output logic [DISP_NUM-1:0][ROB_DEPTH-1:0]   vs1_sel,
  output logic [DISP_NUM-1:0][ROB_DEPTH-1:0]   vs2_sel,
  output logic [DISP_NUM-1:0][ROB_DEPTH-1:0]   vd_sel,
  output logic [DISP_NUM-1:0][ROB_DEPTH-1:0]   v0_sel,
  output logic                                 stall_timeout
`ifdef RVV_DISPATCH_STALL_PERF_EN
  ,
  output logic [31:0]                          stall_cycle_cnt
`endif
);

  localparam int unsigned FREE_W = $clog2(ROB_DEPTH) + 1;
  localparam int unsigned CNT_W  = $clog2(STALL_TIMEOUT) + 1;

  DISP_SCHED_STATE_e            state_q, state_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
  logic                         stall_timeout_q, stall_timeout_d;
  logic [DISP_NUM-1:0]          disp_valid_q;
  DISP_RAW_SEL_t [DISP_NUM-1:0] sel_q, sel_d, sel_raw;
  logic [DISP_NUM-1:0]          lane_ok, lane_wait;
  logic                         prefix;

  for (genvar k = 0; k < DISP_NUM; k++) begin : g_lane
    assign lane_wait[k] = raw_uop_rob[k].vs1_wait | raw_uop_rob[k].vs2_wait |
                          raw_uop_rob[k].vd_wait  | raw_uop_rob[k].v0_wait;

    if (k == 0) begin : g_oldest
      assign lane_ok[k] = uop_valid[k] & ~lane_wait[k] & rs_ready[k] &
                          (rob_free_num >= FREE_W'(k + 1));
    end else begin : g_younger
      // Younger lanes also stall on a producer that sits earlier in this same bundle.
      assign lane_ok[k] = uop_valid[k] & ~lane_wait[k] & rs_ready[k] &
                          (rob_free_num >= FREE_W'(k + 1)) & ~raw_uop_uop[k-1];
    end

    rvv_backend_dispatch_youngest_sel #(.ROB_DEPTH(ROB_DEPTH)) u_vs1_sel (
      .hit_i(raw_uop_rob[k].vs1_hit), .head_i(rob_head_ptr), .sel_o(sel_raw[k].vs1));
    rvv_backend_dispatch_youngest_sel #(.ROB_DEPTH(ROB_DEPTH)) u_vs2_sel (
      .hit_i(raw_uop_rob[k].vs2_hit), .head_i(rob_head_ptr), .sel_o(sel_raw[k].vs2));
    rvv_backend_dispatch_youngest_sel #(.ROB_DEPTH(ROB_DEPTH)) u_vd_sel (
      .hit_i(raw_uop_rob[k].vd_hit),  .head_i(rob_head_ptr), .sel_o(sel_raw[k].vd));
    rvv_backend_dispatch_youngest_sel #(.ROB_DEPTH(ROB_DEPTH)) u_v0_sel (
      .hit_i(raw_uop_rob[k].v0_hit),  .head_i(rob_head_ptr), .sel_o(sel_raw[k].v0));
  end

  always_comb begin
    uop_ready = '0;
    sel_d     = '0;
    prefix    = (state_q != FLUSH) & ~trap_flush;
    for (int k = 0; k < DISP_NUM; k++) begin
      prefix       = prefix & lane_ok[k];
      uop_ready[k] = prefix;
      if (prefix) sel_d[k] = sel_raw[k];
    end
  end

  // Only a RAW wait on lane 0 counts as a stall; ROB/RS back-pressure stays in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (uop_valid[0] & lane_wait[0]) state_d = STALL;
      STALL:   if (uop_ready[0] | ~uop_valid[0]) state_d = RUN;
      FLUSH:   if (rob_free_num == FREE_W'(ROB_DEPTH)) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (trap_flush) state_d = FLUSH;
  end

  always_comb begin
    stall_cnt_d = '0;
    if (state_q == STALL) begin
      stall_cnt_d = (stall_cnt_q == CNT_W'(STALL_TIMEOUT)) ? stall_cnt_q
                                                           : stall_cnt_q + CNT_W'(1);
    end
    stall_timeout_d = stall_timeout_q | (stall_cnt_d == CNT_W'(STALL_TIMEOUT));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
      disp_valid_q    <= '0;
      // NOTE: the select registers feed a bypass mux directly, so they are reset rather than left X.
      sel_q           <= '0;
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
      disp_valid_q    <= uop_ready;
      sel_q           <= sel_d;
    end
  end

  assign disp_valid    = disp_valid_q;
  assign stall_timeout = stall_timeout_q;

  for (genvar k = 0; k < DISP_NUM; k++) begin : g_out
    assign vs1_sel[k] = sel_q[k].vs1;
    assign vs2_sel[k] = sel_q[k].vs2;
    assign vd_sel[k]  = sel_q[k].vd;
    assign v0_sel[k]  = sel_q[k].v0;
  end

`ifdef RVV_DISPATCH_STALL_PERF_EN
  logic [31:0] stall_cycle_cnt_q;

  // Lifetime count: survives flushes, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycle_cnt_q <= '0;
    end else if ((state_q == STALL) && (stall_cycle_cnt_q != '1)) begin
      stall_cycle_cnt_q <= stall_cycle_cnt_q + 32'd1;
    end
  end

  assign stall_cycle_cnt = stall_cycle_cnt_q;
`endif

endmodule

// File: tb/tb_rvv_backend_dispatch_raw_sched.sv
// Scoreboard bench for rvv_backend_dispatch_raw_sched: directed scenarios then random traffic
// against a behavioural model; a monitor pops expectations as the DUT presents outputs.
module tb_rvv_backend_dispatch_raw_sched;
  import rvv_backend_dispatch_pkg::*;

  localparam int D  = RVV_ROB_DEPTH;
  localparam int N  = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]            uop_valid, uop_ready, rs_ready, disp_valid;
  RAW_UOP_ROB_t [N-1:0]    raw_uop_rob;
  logic [0:0]              raw_uop_uop;
  logic [$clog2(D)-1:0]    rob_head_ptr;
  logic [$clog2(D):0]      rob_free_num;
  logic                    trap_flush, stall_timeout;
  logic [N-1:0][D-1:0]     vs1_sel, vs2_sel, vd_sel, v0_sel;
`ifdef RVV_DISPATCH_STALL_PERF_EN
  logic [31:0]             stall_cycle_cnt;
`endif

  rvv_backend_dispatch_raw_sched #(.DISP_NUM(N), .ROB_DEPTH(D), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .raw_uop_rob(raw_uop_rob), .raw_uop_uop(raw_uop_uop), .rob_head_ptr(rob_head_ptr),
    .rob_free_num(rob_free_num), .rs_ready(rs_ready), .trap_flush(trap_flush),
    .disp_valid(disp_valid), .vs1_sel(vs1_sel), .vs2_sel(vs2_sel), .vd_sel(vd_sel),
    .v0_sel(v0_sel), .stall_timeout(stall_timeout)
`ifdef RVV_DISPATCH_STALL_PERF_EN
    , .stall_cycle_cnt(stall_cycle_cnt)
`endif
  );

  // Staged stimulus, applied to the DUT at the next falling edge.
  logic [N-1:0]         s_valid, s_rs;
  RAW_UOP_ROB_t [N-1:0] s_rob;
  logic [0:0]           s_uu;
  logic [$clog2(D)-1:0] s_head;
  logic [$clog2(D):0]   s_free;
  logic                 s_trap;

  typedef struct {
    logic [N-1:0]        dv;
    logic [N-1:0][D-1:0] vs1, vs2, vd, v0;
    logic                to;
    longint              perf;
  } exp_t;

  logic [N-1:0] q_ready[$];
  exp_t         q_out[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit     m_flush, m_stall, m_to;
  int     m_cnt;
  longint m_perf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [D-1:0] youngest(input logic [D-1:0] hit, input int head);
    logic [D-1:0] r = '0;
    int best = -1;
    for (int i = 0; i < D; i++) begin
      int age = (i - head + D) % D;
      if (hit[i] && age > best) begin
        best = age;
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic bit waits(input int k);
    return s_rob[k].vs1_wait || s_rob[k].vs2_wait || s_rob[k].vd_wait || s_rob[k].v0_wait;
  endfunction

  function automatic bit lane_ok(input int k);
    bit ok = s_valid[k] && !waits(k) && s_rs[k] && (int'(s_free) >= k + 1);
    if (k > 0 && s_uu[k-1]) ok = 0;
    return ok;
  endfunction

  task automatic set_idle();
    s_valid = '0; s_rob = '0; s_uu = '0; s_head = '0;
    s_free = ($clog2(D)+1)'(D); s_rs = '1; s_trap = 1'b0;
  endtask

  task automatic model_reset();
    m_flush = 0; m_stall = 0; m_to = 0; m_cnt = 0; m_perf = 0;
  endtask

  task automatic step();
    logic [N-1:0] rdy;
    exp_t e;
    int n = 0;
    @(negedge clk);
    uop_valid = s_valid; raw_uop_rob = s_rob; raw_uop_uop = s_uu; rob_head_ptr = s_head;
    rob_free_num = s_free; rs_ready = s_rs; trap_flush = s_trap;
    // Ready = the longest run of acceptable lanes starting at the oldest.
    if (!m_flush && !s_trap) while (n < N && lane_ok(n)) n++;
    rdy = N'((1 << n) - 1);
    q_ready.push_back(rdy);
    e.dv = rdy;
    for (int k = 0; k < N; k++) begin
      e.vs1[k] = rdy[k] ? youngest(s_rob[k].vs1_hit, int'(s_head)) : '0;
      e.vs2[k] = rdy[k] ? youngest(s_rob[k].vs2_hit, int'(s_head)) : '0;
      e.vd[k]  = rdy[k] ? youngest(s_rob[k].vd_hit,  int'(s_head)) : '0;
      e.v0[k]  = rdy[k] ? youngest(s_rob[k].v0_hit,  int'(s_head)) : '0;
    end
    if (m_stall) begin
      m_perf++;
      if (m_cnt < TO) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    if (m_cnt >= TO) m_to = 1;
    e.to = m_to; e.perf = m_perf;
    q_out.push_back(e);
    if (s_trap) begin
      m_flush = 1; m_stall = 0;
    end else if (m_flush) begin
      if (int'(s_free) == D) m_flush = 0;
    end else if (m_stall) begin
      if (rdy[0] || !s_valid[0]) m_stall = 0;
    end else if (s_valid[0] && waits(0)) begin
      m_stall = 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " disp_valid"}, 64'(disp_valid), 64'd0);
    check({tag, " sel"}, {vs1_sel, vs2_sel, vd_sel, v0_sel}, 64'd0);
    check({tag, " stall_timeout"}, 64'(stall_timeout), 64'd0);
`ifdef RVV_DISPATCH_STALL_PERF_EN
    check({tag, " stall_cycle_cnt"}, 64'(stall_cycle_cnt), 64'd0);
`endif
  endtask

  // Asynchronous reset placed between clock edges, after the monitor has drained this cycle.
  task automatic async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : mon_ready
    logic [N-1:0] r;
    forever begin
      @(negedge clk);
      #2;
      if (q_ready.size() > 0) begin
        r = q_ready.pop_front();
        check("uop_ready", 64'(uop_ready), 64'(r));
      end
    end
  end

  initial begin : mon_out
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_out.size() > 0) begin
        e = q_out.pop_front();
        check("disp_valid", 64'(disp_valid), 64'(e.dv));
        check("vs1_sel", 64'(vs1_sel), 64'(e.vs1));
        check("vs2_sel", 64'(vs2_sel), 64'(e.vs2));
        check("vd_sel", 64'(vd_sel), 64'(e.vd));
        check("v0_sel", 64'(v0_sel), 64'(e.v0));
        check("stall_timeout", 64'(stall_timeout), 64'(e.to));
`ifdef RVV_DISPATCH_STALL_PERF_EN
        check("stall_cycle_cnt", 64'(stall_cycle_cnt), 64'(e.perf));
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stim
    set_idle();
    uop_valid = '0; raw_uop_rob = '0; raw_uop_uop = '0; rob_head_ptr = '0;
    rob_free_num = ($clog2(D)+1)'(D); rs_ready = '1; trap_flush = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10 check_reset_outputs("power-on reset");
    #1 rst_n = 1'b1;

    // Both lanes clean.
    s_valid = 2'b11; step();
    // Intra-bundle dependence blocks lane 1 only.
    s_uu = 1'b1; step(); s_uu = 1'b0;
    // ROB capacity limits and RS back-pressure.
    s_free = 1; step();
    s_free = 0; step();
    s_free = ($clog2(D)+1)'(D);
    s_rs = 2'b10; step();
    s_rs = 2'b01; step();
    s_rs = 2'b11;
    // Youngest select across head wrap.
    s_head = 6; s_rob[0].vs2_hit = 8'b0100_0001; s_rob[1].vd_hit = 8'b1010_0000; step();
    s_head = 7; step();
    s_rob[1].v0_hit = 8'b0111_1111; s_head = 0; step();
    s_rob = '0; s_head = 0;
    // Short RAW stall (below the timeout).
    s_rob[0].vs1_wait = 1'b1; repeat (3) step();
    s_rob[0].vs1_wait = 1'b0; step();
    // Resource-only block must not count as a stall.
    s_rs = 2'b00; repeat (8) step();
    s_rs = 2'b11; step();
    // Flush arriving while stalled; ROB drains three cycles later.
    s_rob[0].vd_wait = 1'b1; repeat (2) step();
    s_rob[0].vd_wait = 1'b0; s_trap = 1'b1; s_free = 5; step();
    s_trap = 1'b0; repeat (2) step();
    s_free = ($clog2(D)+1)'(D); step();
    step();
    // Five-cycle stall crosses the timeout; flag stays set afterwards.
    s_rob[0].vs1_wait = 1'b1; repeat (5) step();
    s_rob[0].vs1_wait = 1'b0; repeat (3) step();
    // Asynchronous reset in the middle of a stall.
    s_rob[0].v0_wait = 1'b1; repeat (3) step();
    async_reset();
    step();
    s_rob[0].v0_wait = 1'b0; repeat (2) step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      s_valid = N'($urandom);
      for (int k = 0; k < N; k++) begin
        s_rob[k].vs1_hit  = D'($urandom) & D'($urandom);
        s_rob[k].vs2_hit  = D'($urandom) & D'($urandom);
        s_rob[k].vd_hit   = D'($urandom) & D'($urandom);
        s_rob[k].v0_hit   = D'($urandom) & D'($urandom);
        s_rob[k].vs1_wait = ($urandom_range(0, 11) == 0);
        s_rob[k].vs2_wait = ($urandom_range(0, 11) == 0);
        s_rob[k].vd_wait  = ($urandom_range(0, 11) == 0);
        s_rob[k].v0_wait  = ($urandom_range(0, 11) == 0);
        s_rs[k]           = ($urandom_range(0, 4) != 0);
      end
      s_uu   = ($urandom_range(0, 3) == 0);
      s_head = ($clog2(D))'($urandom);
      s_free = ($clog2(D)+1)'($urandom_range(0, D));
      s_trap = ($urandom_range(0, 29) == 0);
      step();
    end

    set_idle();
    repeat (2) step();
    @(posedge clk);
    #3 check("scoreboard drained", 64'(q_ready.size() + q_out.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
